// File: rtl/simple_bus.sv
// simple_bus: fixed-priority N-host / M-device bus with a one-cycle
// pipelined response path.
//
// Ports
//   clk_i, rst_i           rising-edge clock, synchronous active-high reset
//   host_*_i / host_*_o    per-host request (req/addr/we/be/wdata), grant and
//                          response (rvalid/rdata/err)
//   device_*_o / *_i       per-device request out and response in
//   cfg_device_addr_*      per-device address region (base, mask)
//
// Grant, decode and the device request are combinational in the request
// cycle. The granted host and the selected device are registered so that the
// device's response can be steered back in the following cycle.
module simple_bus #(
  parameter int unsigned NrDevices    = 1,
  parameter int unsigned NrHosts      = 1,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned AddressWidth = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_i,

  input  logic                      host_req_i    [NrHosts],
  output logic                      host_gnt_o    [NrHosts],
  input  logic [AddressWidth-1:0]   host_addr_i   [NrHosts],
  input  logic                      host_we_i     [NrHosts],
  input  logic [DataWidth/8-1:0]    host_be_i     [NrHosts],
  input  logic [DataWidth-1:0]      host_wdata_i  [NrHosts],
  output logic                      host_rvalid_o [NrHosts],
  output logic [DataWidth-1:0]      host_rdata_o  [NrHosts],
  output logic                      host_err_o    [NrHosts],

  output logic                      device_req_o    [NrDevices],
  output logic [AddressWidth-1:0]   device_addr_o   [NrDevices],
  output logic                      device_we_o     [NrDevices],
  output logic [DataWidth/8-1:0]    device_be_o     [NrDevices],
  output logic [DataWidth-1:0]      device_wdata_o  [NrDevices],
  input  logic                      device_rvalid_i [NrDevices],
  input  logic [DataWidth-1:0]      device_rdata_i  [NrDevices],
  input  logic                      device_err_i    [NrDevices],

  input  logic [AddressWidth-1:0]   cfg_device_addr_base [NrDevices],
  input  logic [AddressWidth-1:0]   cfg_device_addr_mask [NrDevices]
);

  localparam int unsigned ByteW    = DataWidth / 8;
  localparam int unsigned HostIdxW = (NrHosts   > 1) ? $clog2(NrHosts)   : 1;
  localparam int unsigned DevIdxW  = (NrDevices > 1) ? $clog2(NrDevices) : 1;

  // Arbitration result and the winner's request payload
  logic                    host_sel_valid;
  logic [HostIdxW-1:0]     host_sel;
  logic [AddressWidth-1:0] win_addr;
  logic                    win_we;
  logic [ByteW-1:0]        win_be;
  logic [DataWidth-1:0]    win_wdata;

  // Address decode result
  logic                    dev_sel_valid;
  logic [DevIdxW-1:0]      dev_sel;

  // Outstanding transaction, captured on each grant
  logic                    rsp_pending;
  logic [HostIdxW-1:0]     rsp_host;
  logic [DevIdxW-1:0]      rsp_dev;
  logic                    rsp_unmapped;

  // Device response selected by the registered device index
  logic                    sel_rvalid;
  logic [DataWidth-1:0]    sel_rdata;
  logic                    sel_err;

  // Fixed priority: scan from the top so the lowest requesting index wins
  always_comb begin : arbiter
    host_sel_valid = 1'b0;
    host_sel       = '0;
    win_addr       = '0;
    win_we         = 1'b0;
    win_be         = '0;
    win_wdata      = '0;
    for (int h = int'(NrHosts) - 1; h >= 0; h--) begin
      if (host_req_i[h]) begin
        host_sel_valid = 1'b1;
        host_sel       = HostIdxW'(h);
        win_addr       = host_addr_i[h];
        win_we         = host_we_i[h];
        win_be         = host_be_i[h];
        win_wdata      = host_wdata_i[h];
      end
    end
  end

  // Region decode: lowest matching device index wins on overlap
  always_comb begin : decoder
    dev_sel_valid = 1'b0;
    dev_sel       = '0;
    for (int d = int'(NrDevices) - 1; d >= 0; d--) begin
      if ((win_addr & cfg_device_addr_mask[d]) == cfg_device_addr_base[d]) begin
        dev_sel_valid = 1'b1;
        dev_sel       = DevIdxW'(d);
      end
    end
  end

  // Zero-latency grant to the winning host only
  always_comb begin : grant
    for (int h = 0; h < int'(NrHosts); h++) begin
      host_gnt_o[h] = host_sel_valid && (host_sel == HostIdxW'(h));
    end
  end

  // Forward the winner's request to the decoded device; idle devices see zeros
  always_comb begin : device_request
    for (int d = 0; d < int'(NrDevices); d++) begin
      device_req_o[d]   = host_sel_valid && dev_sel_valid && (dev_sel == DevIdxW'(d));
      device_addr_o[d]  = device_req_o[d] ? win_addr  : '0;
      device_we_o[d]    = device_req_o[d] ? win_we    : 1'b0;
      device_be_o[d]    = device_req_o[d] ? win_be    : '0;
      device_wdata_o[d] = device_req_o[d] ? win_wdata : '0;
    end
  end

  // Remember who was granted and where it went, for the response cycle
  always_ff @(posedge clk_i) begin : rsp_track
    if (rst_i) begin
      rsp_pending  <= 1'b0;
      rsp_host     <= '0;
      rsp_dev      <= '0;
      rsp_unmapped <= 1'b0;
    end else begin
      rsp_pending  <= host_sel_valid;
      rsp_host     <= host_sel;
      rsp_dev      <= dev_sel;
      rsp_unmapped <= host_sel_valid && !dev_sel_valid;
    end
  end

  // Pick the response of the device that owns the outstanding transaction;
  // responses from any other device are never looked at
  always_comb begin : rsp_mux
    sel_rvalid = 1'b0;
    sel_rdata  = '0;
    sel_err    = 1'b0;
    for (int d = 0; d < int'(NrDevices); d++) begin
      if (rsp_dev == DevIdxW'(d)) begin
        sel_rvalid = device_rvalid_i[d];
        sel_rdata  = device_rdata_i[d];
        sel_err    = device_err_i[d];
      end
    end
  end

  // Steer the response to the registered host. Gating with rst_i drops a
  // transaction whose response cycle coincides with reset.
  always_comb begin : host_response
    for (int h = 0; h < int'(NrHosts); h++) begin
      host_rvalid_o[h] = 1'b0;
      host_rdata_o[h]  = '0;
      host_err_o[h]    = 1'b0;
      if (rsp_pending && !rst_i && (rsp_host == HostIdxW'(h))) begin
        if (rsp_unmapped) begin
          // Bus-generated error response for an address no device claims
          host_rvalid_o[h] = 1'b1;
          host_err_o[h]    = 1'b1;
        end else begin
          host_rvalid_o[h] = sel_rvalid;
          host_rdata_o[h]  = sel_rdata;
          host_err_o[h]    = sel_err;
        end
      end
    end
  end

endmodule

// File: tb/tb_simple_bus.sv
// Bench for simple_bus with 2 hosts and 3 devices (Ram, SimCtrl, Timer).
// Each table row drives one cycle and states the expected grant and device
// request; its expected response is queued and checked one cycle later.
module tb_simple_bus;

  localparam int NH = 2;
  localparam int ND = 3;

  // Device response pattern: rdata = PAT[d] ^ addr[15:0]; Timer errors on writes
  localparam logic [31:0] PAT [ND] = '{32'hDEAD_BEFF, 32'h5100_0000, 32'h7100_0000};

  typedef struct {
    logic        rst;
    logic [2:0]  stray;
    logic        r0;  logic [31:0] a0; logic w0; logic [3:0] b0; logic [31:0] d0;
    logic        r1;  logic [31:0] a1; logic w1; logic [3:0] b1; logic [31:0] d1;
    logic [1:0]  eg;
    logic [2:0]  ed;
    logic        hr;
    int          rh;
    logic [31:0] rd;
    logic        re;
  } vec_t;

  typedef struct {
    int          host;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        host_req    [NH];
  logic        host_gnt_o  [NH];
  logic [31:0] host_addr   [NH];
  logic        host_we     [NH];
  logic [3:0]  host_be     [NH];
  logic [31:0] host_wdata  [NH];
  logic        host_rvalid_o [NH];
  logic [31:0] host_rdata_o  [NH];
  logic        host_err_o    [NH];

  logic        device_req_o   [ND];
  logic [31:0] device_addr_o  [ND];
  logic        device_we_o    [ND];
  logic [3:0]  device_be_o    [ND];
  logic [31:0] device_wdata_o [ND];
  logic        device_rvalid  [ND];
  logic [31:0] device_rdata   [ND];
  logic        device_err     [ND];
  logic [31:0] cfg_base [ND];
  logic [31:0] cfg_mask [ND];

  logic [2:0]  stray;
  logic        dev_rv_q   [ND];
  logic [31:0] dev_addr_q [ND];
  logic        dev_we_q   [ND];

  rsp_t sb[$];
  vec_t vecs[$];
  int   n_vec = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  simple_bus #(
    .NrDevices(ND), .NrHosts(NH), .DataWidth(32), .AddressWidth(32)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .host_req_i(host_req), .host_gnt_o(host_gnt_o), .host_addr_i(host_addr),
    .host_we_i(host_we), .host_be_i(host_be), .host_wdata_i(host_wdata),
    .host_rvalid_o(host_rvalid_o), .host_rdata_o(host_rdata_o), .host_err_o(host_err_o),
    .device_req_o(device_req_o), .device_addr_o(device_addr_o), .device_we_o(device_we_o),
    .device_be_o(device_be_o), .device_wdata_o(device_wdata_o),
    .device_rvalid_i(device_rvalid), .device_rdata_i(device_rdata), .device_err_i(device_err),
    .cfg_device_addr_base(cfg_base), .cfg_device_addr_mask(cfg_mask)
  );

  // Device model: answers exactly one cycle after its request; stray injects
  // an unsolicited rvalid
  always @(posedge clk) begin
    for (int d = 0; d < ND; d++) begin
      dev_rv_q[d]   <= device_req_o[d];
      dev_addr_q[d] <= device_addr_o[d];
      dev_we_q[d]   <= device_we_o[d];
    end
  end

  always_comb begin
    for (int d = 0; d < ND; d++) begin
      device_rvalid[d] = dev_rv_q[d] | stray[d];
      device_rdata[d]  = PAT[d] ^ {16'h0, dev_addr_q[d][15:0]};
      device_err[d]    = dev_rv_q[d] & dev_we_q[d] & (d == 2);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mkv(
      logic r0, logic [31:0] a0, logic w0, logic [3:0] b0, logic [31:0] d0,
      logic r1, logic [31:0] a1, logic w1, logic [3:0] b1, logic [31:0] d1,
      logic [1:0] eg, logic [2:0] ed, logic hr, int rh, logic [31:0] rd, logic re);
    vec_t v;
    v.rst = 1'b0; v.stray = 3'b000;
    v.r0 = r0; v.a0 = a0; v.w0 = w0; v.b0 = b0; v.d0 = d0;
    v.r1 = r1; v.a1 = a1; v.w1 = w1; v.b1 = b1; v.d1 = d1;
    v.eg = eg; v.ed = ed; v.hr = hr; v.rh = rh; v.rd = rd; v.re = re;
    return v;
  endfunction

  function automatic vec_t idle();
    return mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0, 0, 0, 0);
  endfunction

  // Drive one cycle, check combinational outputs and the response queued last cycle
  task automatic apply(input vec_t v, input string tag);
    rsp_t        e;
    logic        erv [NH];
    logic [31:0] erd [NH];
    logic        eer [NH];
    logic [31:0] wa, wd;
    logic        ww;
    logic [3:0]  wb;
    logic [1:0]  gv;
    logic [2:0]  dv;

    rst = v.rst;
    stray = v.stray;
    host_req[0] = v.r0; host_addr[0] = v.a0; host_we[0] = v.w0; host_be[0] = v.b0; host_wdata[0] = v.d0;
    host_req[1] = v.r1; host_addr[1] = v.a1; host_we[1] = v.w1; host_be[1] = v.b1; host_wdata[1] = v.d1;
    if (v.rst) sb.delete();

    @(negedge clk);
    n_vec++;

    for (int h = 0; h < NH; h++) begin
      erv[h] = 1'b0; erd[h] = '0; eer[h] = 1'b0;
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      erv[e.host] = 1'b1; erd[e.host] = e.rdata; eer[e.host] = e.err;
    end
    for (int h = 0; h < NH; h++) begin
      chk($sformatf("%s rvalid[%0d]", tag, h), 32'(host_rvalid_o[h]), 32'(erv[h]));
      chk($sformatf("%s rdata[%0d]", tag, h), host_rdata_o[h], erd[h]);
      chk($sformatf("%s err[%0d]", tag, h), 32'(host_err_o[h]), 32'(eer[h]));
    end

    gv = {host_gnt_o[1], host_gnt_o[0]};
    dv = {device_req_o[2], device_req_o[1], device_req_o[0]};
    chk({tag, " gnt"}, 32'(gv), 32'(v.eg));
    chk({tag, " device_req"}, 32'(dv), 32'(v.ed));

    wa = '0; ww = 1'b0; wb = '0; wd = '0;
    if (v.eg[0]) begin
      wa = v.a0; ww = v.w0; wb = v.b0; wd = v.d0;
    end else if (v.eg[1]) begin
      wa = v.a1; ww = v.w1; wb = v.b1; wd = v.d1;
    end
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("%s dev_addr[%0d]", tag, d), device_addr_o[d], v.ed[d] ? wa : 32'h0);
      chk($sformatf("%s dev_we[%0d]", tag, d), 32'(device_we_o[d]), v.ed[d] ? 32'(ww) : 32'h0);
      chk($sformatf("%s dev_be[%0d]", tag, d), 32'(device_be_o[d]), v.ed[d] ? 32'(wb) : 32'h0);
      chk($sformatf("%s dev_wdata[%0d]", tag, d), device_wdata_o[d], v.ed[d] ? wd : 32'h0);
    end

    if (v.hr) begin
      e.host = v.rh; e.rdata = v.rd; e.err = v.re;
      sb.push_back(e);
    end

    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
    $fatal(1);
  end

  initial begin
    vec_t v;

    cfg_base[0] = 32'h0010_0000; cfg_mask[0] = 32'hFFF0_0000;  // Ram
    cfg_base[1] = 32'h0002_0000; cfg_mask[1] = 32'hFFFF_FC00;  // SimCtrl
    cfg_base[2] = 32'h0003_0000; cfg_mask[2] = 32'hFFFF_FC00;  // Timer

    // Reset state
    v = idle(); v.rst = 1'b1;
    apply(v, "reset0");
    apply(v, "reset1");

    // r0 a0 w0 b0 d0 | r1 a1 w1 b1 d1 | gnt dreq | rsp host rdata err
    vecs.push_back(mkv(1, 32'h0010_0010, 0, 4'hF, 0,      0, 0, 0, 0, 0,                       2'b01, 3'b001, 1, 0, 32'hDEAD_BEEF, 0));
    vecs.push_back(mkv(1, 32'h0002_0000, 1, 4'h1, 32'h41, 0, 0, 0, 0, 0,                       2'b01, 3'b010, 1, 0, 32'h5100_0000, 0));
    vecs.push_back(mkv(1, 32'h0004_0000, 0, 4'hF, 0,      0, 0, 0, 0, 0,                       2'b01, 3'b000, 1, 0, 32'h0,         1));
    vecs.push_back(mkv(1, 32'h0003_0004, 0, 4'hF, 0,      0, 0, 0, 0, 0,                       2'b01, 3'b100, 1, 0, 32'h7100_0004, 0));
    vecs.push_back(mkv(1, 32'h0010_0000, 0, 4'hF, 0,      0, 0, 0, 0, 0,                       2'b01, 3'b001, 1, 0, 32'hDEAD_BEFF, 0));
    vecs.push_back(mkv(1, 32'h0002_0010, 0, 4'h3, 0,      1, 32'h0003_0008, 0, 4'hF, 0,        2'b01, 3'b010, 1, 0, 32'h5100_0010, 0));
    vecs.push_back(mkv(0, 0, 0, 0, 0,                     1, 32'h0003_0008, 0, 4'hF, 0,        2'b10, 3'b100, 1, 1, 32'h7100_0008, 0));
    vecs.push_back(mkv(0, 0, 0, 0, 0,                     1, 32'h0003_0010, 1, 4'hF, 32'h1234, 2'b10, 3'b100, 1, 1, 32'h7100_0010, 1));
    vecs.push_back(mkv(1, 32'h0002_03FF, 0, 4'h4, 0,      0, 0, 0, 0, 0,                       2'b01, 3'b010, 1, 0, 32'h5100_03FF, 0));
    vecs.push_back(mkv(1, 32'h0002_0400, 0, 4'hF, 0,      1, 32'h0010_0004, 1, 4'h2, 32'hCAFE, 2'b01, 3'b000, 1, 0, 32'h0,         1));
    vecs.push_back(mkv(0, 0, 0, 0, 0,                     1, 32'h0010_0004, 1, 4'h2, 32'hCAFE, 2'b10, 3'b001, 1, 1, 32'hDEAD_BEFB, 0));
    vecs.push_back(mkv(0, 0, 0, 0, 0,                     1, 32'h0000_03FF, 0, 4'hF, 0,        2'b10, 3'b000, 1, 1, 32'h0,         1));
    vecs.push_back(idle());
    vecs.push_back(idle());

    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    // Unsolicited rvalid from SimCtrl with nothing outstanding
    v = idle(); v.stray = 3'b010;
    apply(v, "stray_idle");
    apply(idle(), "stray_idle_after");

    // Unsolicited rvalid from Timer while a Ram read is outstanding
    apply(mkv(1, 32'h0010_0010, 0, 4'hF, 0, 0, 0, 0, 0, 0, 2'b01, 3'b001, 1, 0, 32'hDEAD_BEEF, 0), "stray_busy_req");
    v = idle(); v.stray = 3'b100;
    apply(v, "stray_busy_rsp");

    // Reset during the response cycle drops the outstanding Timer read
    apply(mkv(1, 32'h0003_0004, 0, 4'hF, 0, 0, 0, 0, 0, 0, 2'b01, 3'b100, 1, 0, 32'h7100_0004, 0), "rst_req");
    v = idle(); v.rst = 1'b1;
    apply(v, "rst_rsp");
    apply(idle(), "rst_after");

    // Bus still works after the reset
    apply(mkv(0, 0, 0, 0, 0, 1, 32'h0002_0008, 0, 4'hF, 0, 2'b10, 3'b010, 1, 1, 32'h5100_0008, 0), "post_rst");
    apply(idle(), "post_rst_rsp");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/simple_bus.md
SIMPLE_BUS -- requirements
Module: simple_bus

Interface
REQ-001 SHALL have parameter NrDevices, default 1, number of device (slave) ports.
REQ-002 SHALL have parameter NrHosts, default 1, number of host (master) ports.
REQ-003 SHALL have parameter DataWidth, default 32, data bus width in bits.
REQ-004 SHALL have parameter AddressWidth, default 32, address width in bits.
REQ-005 SHALL use one clock and a synchronous, active-high reset: clk_i input 1 (rising-edge clock); rst_i input 1 (synchronous active-high reset).
REQ-006 SHALL have host ports, each an unpacked array [NrHosts]:
- host_req_i in 1: request
- host_gnt_o out 1: grant
- host_addr_i in AddressWidth: address
- host_we_i in 1: write enable
- host_be_i in DataWidth/8: byte enables
- host_wdata_i in DataWidth: write data
- host_rvalid_o out 1: response valid
- host_rdata_o out DataWidth: read data
- host_err_o out 1: response error
REQ-007 SHALL have device ports, each an unpacked array [NrDevices]:
- device_req_o out 1
- device_addr_o out AddressWidth
- device_we_o out 1
- device_be_o out DataWidth/8
- device_wdata_o out DataWidth
- device_rvalid_i in 1
- device_rdata_i in DataWidth
- device_err_i in 1
REQ-008 SHALL have address-map inputs, each an unpacked array [NrDevices]:
- cfg_device_addr_base in AddressWidth: region base
- cfg_device_addr_mask in AddressWidth: region mask

Function
REQ-009 SHALL arbitrate by fixed priority: lowest-index requesting host wins, combinationally, every cycle.
REQ-010 SHALL decode the winning address as device d when (addr & cfg_device_addr_mask[d]) == cfg_device_addr_base[d]; lowest matching index wins.
REQ-011 SHALL, when the winner decodes to device d, drive device_req_o[d]=1 and pass the winner's addr/we/be/wdata to device d, all combinationally in the same cycle.
REQ-012 SHALL hold device_req_o=0 for all non-selected devices; their addr/we/be/wdata are don't-care and driven to 0.
REQ-013 SHALL assert host_gnt_o only for the winning host, in the same cycle as its request (zero-latency grant, no backpressure); host_gnt_o=0 for all others.
REQ-014 SHALL register the granted host index and the device index (or an "unmapped" flag) on each grant, for use in the following cycle.
REQ-015 SHALL require every device to assert device_rvalid_i exactly one cycle after device_req_o; the bus supports one transaction per cycle, pipelined back-to-back.
REQ-016 SHALL route device_rvalid_i, device_rdata_i and device_err_i of the registered device to the registered host in the response cycle; all other hosts see rvalid=0, rdata=0, err=0.
REQ-017 SHALL, for an unmapped address: grant the host, assert no device_req_o, and respond next cycle with host_rvalid_o=1, host_err_o=1, host_rdata_o=0.
REQ-018 SHALL ignore a device_rvalid_i that arrives with no outstanding transaction to that device.
REQ-019 SHALL allow a new grant in the same cycle as the previous transaction's response.
REQ-020 SHALL make a losing host simply wait: its request stays asserted until granted, with no starvation protection.

Reset
REQ-021 SHALL clear the registered host/device selection and unmapped flag while rst_i=1, so all host_rvalid_o=0 in the cycle after reset.
REQ-022 SHALL drop any transaction outstanding at reset; its response is not forwarded.

Structure
REQ-023 SHALL be self-contained with no shared package; index widths are derived locally from NrHosts and NrDevices (minimum 1 bit).
REQ-024 SHALL implement arbitration and decode as local combinational logic; no sub-module is required.

Verification
REQ-025 Map Ram base 0x100000 mask 0xFFF00000; SimCtrl base 0x20000 mask 0xFFFFFC00; Timer base 0x30000 mask 0xFFFFFC00.
- Host0 reads 0x100010 -> gnt and device_req_o[Ram] same cycle; device returns rdata 0xDEADBEEF next cycle -> host_rvalid_o=1, rdata 0xDEADBEEF, err=0.
REQ-026 Host0 writes 0x20000, wdata 0x41, be 0x1 -> only device_req_o[SimCtrl]=1 with identical wdata/be/we.
REQ-027 Host0 reads 0x40000 (unmapped) -> gnt=1, no device_req_o, next cycle rvalid=1, err=1, rdata=0.
REQ-028 Back-to-back reads 0x30004 then 0x100000 -> responses return in consecutive cycles, each routed from the correct device.
REQ-029 With NrHosts=2, both hosts request in the same cycle -> host0 granted; host1 granted the next cycle, and its response reaches host_rvalid_o[1] only.
REQ-030 Assert rst_i while a transaction is outstanding -> no host_rvalid_o in the following cycle.
